// File: rtl/ssd_scan_driver_if.sv
// Symbol bus and display pins between the lock controller and the scan driver.
// master: drives ssd_in/blink_mask, sees AN/seven_out/frame_done; slave: the driver.
interface ssd_scan_driver_if;
  logic [19:0] ssd_in;
  logic [3:0]  blink_mask;
  logic [3:0]  AN;
  logic [6:0]  seven_out;
  logic        frame_done;

  modport master (
    output ssd_in,
    output blink_mask,
    input  AN,
    input  seven_out,
    input  frame_done
  );

  modport slave (
    input  ssd_in,
    input  blink_mask,
    output AN,
    output seven_out,
    output frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver: latches the symbol bus once per frame,
// decodes 5-bit symbols to active-low segments and blanks masked digits.
// Ports: clk, rst (async, active-high), bus (slave: ssd_in, blink_mask in;
// AN, seven_out, frame_done out).
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input logic              clk,
  input logic              rst,
  ssd_scan_driver_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  localparam logic [4:0]  SYM_BLANK = 5'd19;
  localparam logic [6:0]  SEG_OFF   = 7'h7F;
  localparam logic [19:0] SSD_BLANK = {4{SYM_BLANK}};

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [19:0]   shadow_ssd;
  logic [3:0]    shadow_mask;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       done_q;

  logic       refresh_wrap;
  logic       blink_wrap;
  logic       frame_end;
  logic [4:0] cur_code;
  logic       blank_now;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h46;
      5'd11:   s = 7'h47;
      5'd12:   s = 7'h12;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h40;
      5'd15:   s = 7'h0C;
      5'd16:   s = 7'h06;
      5'd17:   s = 7'h2B;
      5'd18:   s = 7'h3F;
      5'd20:   s = 7'h2F;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_comb begin
    refresh_wrap = (refresh_cnt == R_LAST);
    blink_wrap   = (blink_cnt == B_LAST);
    // Frame ends when digit 0's slot expires; the bus is sampled right here.
    frame_end    = refresh_wrap && (digit_idx == 2'd0);

    cur_code = SYM_BLANK;
    unique case (digit_idx)
      2'd3: cur_code = shadow_ssd[19:15];
      2'd2: cur_code = shadow_ssd[14:10];
      2'd1: cur_code = shadow_ssd[9:5];
      2'd0: cur_code = shadow_ssd[4:0];
    endcase

    blank_now = blink_phase && shadow_mask[digit_idx];

    an_next            = 4'b1111;
    an_next[digit_idx] = 1'b0;
    seg_next           = decode(cur_code);
    if (blank_now) begin
      an_next  = 4'b1111;
      seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd3;
    end else if (refresh_wrap) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx - 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_ssd  <= SSD_BLANK;
      shadow_mask <= 4'b0000;
      done_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (frame_end) begin
        shadow_ssd  <= bus.ssd_in;
        shadow_mask <= bus.blink_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign bus.AN         = an_q;
  assign bus.seven_out  = seg_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with REFRESH_DIV=4, BLINK_DIV=64.
// Edge counter e counts rising edges since the last reset release.
module tb_ssd_scan_driver;
  localparam int RD = 4;
  localparam int BD = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  ssd_scan_driver_if bus();

  ssd_scan_driver #(
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic test_reset();
    bus.ssd_in     = {5'd10, 5'd11, 5'd12, 5'd13};
    bus.blink_mask = 4'b0000;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (bus.AN !== 4'b1111) begin
      errors++;
      $display("FAIL reset_an got %b exp 1111", bus.AN);
    end
    if (bus.seven_out !== 7'h7F) begin
      errors++;
      $display("FAIL reset_seg got %h exp 7f", bus.seven_out);
    end
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b exp 0", bus.frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic test_blank_frame();
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 3;
      if (bus.AN !== an_tab[i/4]) begin
        errors++;
        $display("FAIL blank_an e=%0d got %b exp %b", e, bus.AN, an_tab[i/4]);
      end
      if (bus.seven_out !== 7'h7F) begin
        errors++;
        $display("FAIL blank_seg e=%0d got %h exp 7f", e, bus.seven_out);
      end
      if (bus.frame_done !== (i == 15)) begin
        errors++;
        $display("FAIL blank_done e=%0d got %b exp %b", e, bus.frame_done, i == 15);
      end
    end
  endtask

  task automatic test_frame_display();
    logic [6:0] xs [4];
    xs = '{7'h46, 7'h47, 7'h12, 7'h21};
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 3;
      if (bus.AN !== an_tab[i/4]) begin
        errors++;
        $display("FAIL disp_an e=%0d got %b exp %b", e, bus.AN, an_tab[i/4]);
      end
      if (bus.seven_out !== xs[i/4]) begin
        errors++;
        $display("FAIL disp_seg e=%0d got %h exp %h", e, bus.seven_out, xs[i/4]);
      end
      if (bus.frame_done !== (i == 15)) begin
        errors++;
        $display("FAIL disp_done e=%0d got %b exp %b", e, bus.frame_done, i == 15);
      end
    end
  endtask

  task automatic test_no_tear();
    logic [6:0] xa [4];
    logic [6:0] xb [4];
    xa = '{7'h46, 7'h47, 7'h12, 7'h21};
    xb = '{7'h40, 7'h0C, 7'h06, 7'h2B};
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 2;
      if (bus.seven_out !== xa[i/4]) begin
        errors++;
        $display("FAIL tear_seg e=%0d got %h exp %h", e, bus.seven_out, xa[i/4]);
      end
      if (bus.frame_done !== (i == 15)) begin
        errors++;
        $display("FAIL tear_done e=%0d got %b exp %b", e, bus.frame_done, i == 15);
      end
      if (i == 5) bus.ssd_in = {5'd14, 5'd15, 5'd16, 5'd17};
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 2;
      if (bus.AN !== an_tab[i/4]) begin
        errors++;
        $display("FAIL new_an e=%0d got %b exp %b", e, bus.AN, an_tab[i/4]);
      end
      if (bus.seven_out !== xb[i/4]) begin
        errors++;
        $display("FAIL new_seg e=%0d got %h exp %h", e, bus.seven_out, xb[i/4]);
      end
      if (i == 8) begin
        bus.ssd_in     = {5'd18, 5'd18, 5'd18, 5'd8};
        bus.blink_mask = 4'b1000;
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] xs [4];
    logic [3:0] xan;
    logic [6:0] xseg;
    int s;
    int ph;
    xs = '{7'h3F, 7'h3F, 7'h3F, 7'h00};
    for (int i = 0; i < 80; i++) begin
      step();
      s  = (i / 4) % 4;
      ph = ((e - 1) / BD) % 2;
      xan  = an_tab[s];
      xseg = xs[s];
      if (ph == 1 && s == 0) begin
        xan  = 4'b1111;
        xseg = 7'h7F;
      end
      checks += 3;
      if (bus.AN !== xan) begin
        errors++;
        $display("FAIL blink_an e=%0d got %b exp %b", e, bus.AN, xan);
      end
      if (bus.seven_out !== xseg) begin
        errors++;
        $display("FAIL blink_seg e=%0d got %h exp %h", e, bus.seven_out, xseg);
      end
      if (bus.frame_done !== (e % 16 == 0)) begin
        errors++;
        $display("FAIL blink_done e=%0d got %b exp %b", e, bus.frame_done, e % 16 == 0);
      end
      if (i == 72) begin
        bus.ssd_in     = {5'd21, 5'd20, 5'd31, 5'd0};
        bus.blink_mask = 4'b0000;
      end
    end
  endtask

  task automatic test_invalid_codes();
    logic [6:0] xs [4];
    xs = '{7'h7F, 7'h2F, 7'h7F, 7'h40};
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 2;
      if (bus.AN !== an_tab[i/4]) begin
        errors++;
        $display("FAIL code_an e=%0d got %b exp %b", e, bus.AN, an_tab[i/4]);
      end
      if (bus.seven_out !== xs[i/4]) begin
        errors++;
        $display("FAIL code_seg e=%0d got %h exp %h", e, bus.seven_out, xs[i/4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step();
    checks += 1;
    if (bus.AN !== 4'b1101) begin
      errors++;
      $display("FAIL mid_pre_an e=%0d got %b exp 1101", e, bus.AN);
    end
    #2 rst = 1'b1;
    bus.ssd_in = {5'd10, 5'd11, 5'd12, 5'd13};
    #1;
    checks += 3;
    if (bus.AN !== 4'b1111) begin
      errors++;
      $display("FAIL mid_an got %b exp 1111", bus.AN);
    end
    if (bus.seven_out !== 7'h7F) begin
      errors++;
      $display("FAIL mid_seg got %h exp 7f", bus.seven_out);
    end
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_done got %b exp 0", bus.frame_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
    test_blank_frame();
    test_frame_display();
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_frame_display();
    test_no_tear();
    test_blink();
    test_invalid_codes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
